// File: rtl/exu_stage.sv
// exu_stage: RV64 execute stage -- forwarding, ALU (incl. M extension), branch compare/target, EX/MEM register.
// Latency: 1 cycle; ALU, forwarding and branch logic are combinational, results land in the exu_* registers.
// Backpressure: none; a MEM-stage redirect (flush_nop) turns the captured instruction into an all-zero bubble.
module exu_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [4:0]      idu_index_rd,
  input  logic [4:0]      idu_index_rs1,
  input  logic [4:0]      idu_index_rs2,
  input  logic [XLEN-1:0] idu_pc,
  input  logic [XLEN-1:0] idu_gpr_data1,
  input  logic [XLEN-1:0] idu_gpr_data2,
  input  logic [XLEN-1:0] idu_imm,
  input  logic [4:0]      idu_alu_opcode,
  input  logic            idu_alu_en,
  input  logic            idu_alu_imm_en,
  input  logic            idu_alu_pc_en,
  input  logic            idu_alu_halfop,
  input  logic [2:0]      idu_branch_opcode,
  input  logic            idu_jump_en,
  input  logic            idu_branch_en,
  input  logic            idu_load_en,
  input  logic [2:0]      idu_load_opcode,
  input  logic            idu_store_en,
  input  logic [3:0]      idu_store_len,
  input  logic            idu_wb_en,
  input  logic [2:0]      idu_wb_choose,
  input  logic [4:0]      mmu_index_rd,
  input  logic [XLEN-1:0] mmu_wb_data,
  input  logic            mmu_wb_en,
  input  logic            mmu_jump_en,
  input  logic            mmu_branch_en,
  output logic [4:0]      exu_index_rd,
  output logic [4:0]      exu_index_rs1,
  output logic [4:0]      exu_index_rs2,
  output logic            exu_jump_en,
  output logic            exu_branch_en,
  output logic [XLEN-1:0] exu_branch_pc,
  output logic            exu_branch_result,
  output logic [XLEN-1:0] exu_alu_result,
  output logic [XLEN-1:0] exu_gpr_data2,
  output logic [XLEN-1:0] exu_imm,
  output logic            exu_load_en,
  output logic [2:0]      exu_load_opcode,
  output logic            exu_store_en,
  output logic [3:0]      exu_store_len,
  output logic            exu_wb_en,
  output logic [2:0]      exu_wb_choose,
  output logic            flush_nop,
  output logic            fw_en1,
  output logic            fw_en2
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  localparam logic [XLEN-1:0] MIN64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [31:0]     MIN32 = 32'h8000_0000;

  // Everything that crosses into MEM, held as one register image
  typedef struct packed {
    logic [4:0]      index_rd;
    logic [4:0]      index_rs1;
    logic [4:0]      index_rs2;
    logic            jump_en;
    logic            branch_en;
    logic [XLEN-1:0] branch_pc;
    logic            branch_result;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] gpr_data2;
    logic [XLEN-1:0] imm;
    logic            load_en;
    logic [2:0]      load_opcode;
    logic            store_en;
    logic [3:0]      store_len;
    logic            wb_en;
    logic [2:0]      wb_choose;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t ex_d;

  logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic [XLEN-1:0] op_a, op_b;
  logic [5:0]      sh64;
  logic [4:0]      sh32;
  logic [31:0]     a32, b32;
  logic            mul_a_sgn, mul_b_sgn;
  logic [XLEN-1:0] mul_a, mul_b;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod;
  logic            div_sgn;
  logic [XLEN-1:0] quo64, rem64;
  logic [31:0]     quo32, rem32;
  logic [XLEN-1:0] res64;
  logic [31:0]     res32;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] alu_sel;
  logic            br_taken;
  logic [XLEN-1:0] br_target;

  // Redirect from MEM squashes the instruction currently in EX
  assign flush_nop = mmu_jump_en | mmu_branch_en;

  // Loads are excluded from EX forwarding: their data does not exist yet and the hazard unit stalls them
  assign ex_hit1  = exu_wb_en && !exu_load_en && (exu_index_rd != 5'd0) && (exu_index_rd == idu_index_rs1);
  assign ex_hit2  = exu_wb_en && !exu_load_en && (exu_index_rd != 5'd0) && (exu_index_rd == idu_index_rs2);
  assign mem_hit1 = mmu_wb_en && (mmu_index_rd != 5'd0) && (mmu_index_rd == idu_index_rs1);
  assign mem_hit2 = mmu_wb_en && (mmu_index_rd != 5'd0) && (mmu_index_rd == idu_index_rs2);

  assign fw_en1 = ex_hit1 | mem_hit1;
  assign fw_en2 = ex_hit2 | mem_hit2;

  // Youngest producer wins: EX result before MEM writeback before the register file
  always_comb begin
    fwd_rs1 = idu_gpr_data1;
    fwd_rs2 = idu_gpr_data2;
    if (ex_hit1)       fwd_rs1 = exu_alu_result;
    else if (mem_hit1) fwd_rs1 = mmu_wb_data;
    if (ex_hit2)       fwd_rs2 = exu_alu_result;
    else if (mem_hit2) fwd_rs2 = mmu_wb_data;
  end

  assign op_a = idu_alu_pc_en  ? idu_pc  : fwd_rs1;
  assign op_b = idu_alu_imm_en ? idu_imm : fwd_rs2;
  assign sh64 = op_b[5:0];
  assign sh32 = op_b[4:0];
  assign a32  = op_a[31:0];
  assign b32  = op_b[31:0];

  // One shared multiplier; W forms feed 32-bit extended operands so the high word sits at [63:32]
  always_comb begin
    mul_a_sgn = (idu_alu_opcode == OP_MULH) || (idu_alu_opcode == OP_MULHSU);
    mul_b_sgn = (idu_alu_opcode == OP_MULH);
    mul_a     = idu_alu_halfop ? {{32{mul_a_sgn & a32[31]}}, a32} : op_a;
    mul_b     = idu_alu_halfop ? {{32{mul_b_sgn & b32[31]}}, b32} : op_b;
    mul_a_ext = {{XLEN{mul_a_sgn & mul_a[XLEN-1]}}, mul_a};
    mul_b_ext = {{XLEN{mul_b_sgn & mul_b[XLEN-1]}}, mul_b};
    prod      = mul_a_ext * mul_b_ext;
  end

  // Divider with the RISC-V divide-by-zero and signed-overflow results
  always_comb begin
    div_sgn = (idu_alu_opcode == OP_DIV) || (idu_alu_opcode == OP_REM);
    if (op_b == '0) begin
      quo64 = '1;
      rem64 = op_a;
    end else if (div_sgn && (op_a == MIN64) && (op_b == '1)) begin
      quo64 = op_a;
      rem64 = '0;
    end else if (div_sgn) begin
      quo64 = $signed(op_a) / $signed(op_b);
      rem64 = $signed(op_a) % $signed(op_b);
    end else begin
      quo64 = op_a / op_b;
      rem64 = op_a % op_b;
    end
    if (b32 == 32'd0) begin
      quo32 = '1;
      rem32 = a32;
    end else if (div_sgn && (a32 == MIN32) && (b32 == '1)) begin
      quo32 = a32;
      rem32 = '0;
    end else if (div_sgn) begin
      quo32 = $signed(a32) / $signed(b32);
      rem32 = $signed(a32) % $signed(b32);
    end else begin
      quo32 = a32 / b32;
      rem32 = a32 % b32;
    end
  end

  // Full-width and word-width results side by side; halfop picks the sign-extended word
  always_comb begin
    res64 = '0;
    res32 = '0;
    case (idu_alu_opcode)
      OP_ADD:    begin res64 = op_a + op_b;  res32 = a32 + b32; end
      OP_SUB:    begin res64 = op_a - op_b;  res32 = a32 - b32; end
      OP_SLL:    begin res64 = op_a << sh64; res32 = a32 << sh32; end
      OP_SLT:    begin
        res64 = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
        res32 = {31'd0, $signed(a32) < $signed(b32)};
      end
      OP_SLTU:   begin
        res64 = {{(XLEN-1){1'b0}}, op_a < op_b};
        res32 = {31'd0, a32 < b32};
      end
      OP_XOR:    begin res64 = op_a ^ op_b;  res32 = a32 ^ b32; end
      OP_SRL:    begin res64 = op_a >> sh64; res32 = a32 >> sh32; end
      OP_SRA:    begin
        res64 = $signed(op_a) >>> sh64;
        res32 = $signed(a32) >>> sh32;
      end
      OP_OR:     begin res64 = op_a | op_b;  res32 = a32 | b32; end
      OP_AND:    begin res64 = op_a & op_b;  res32 = a32 & b32; end
      OP_PASSB:  begin res64 = op_b;         res32 = b32; end
      OP_MUL:    begin res64 = prod[XLEN-1:0]; res32 = prod[31:0]; end
      OP_MULH, OP_MULHSU, OP_MULHU: begin
        res64 = prod[2*XLEN-1:XLEN];
        res32 = prod[63:32];
      end
      OP_DIV, OP_DIVU: begin res64 = quo64; res32 = quo32; end
      OP_REM, OP_REMU: begin res64 = rem64; res32 = rem32; end
      default:   begin res64 = '0; res32 = '0; end
    endcase
    alu_out = idu_alu_halfop ? {{(XLEN-32){res32[31]}}, res32} : res64;
  end

  // Jumps write the link address; instructions without an ALU op write zero
  always_comb begin
    if (idu_jump_en)      alu_sel = idu_pc + XLEN'(4);
    else if (!idu_alu_en) alu_sel = '0;
    else                  alu_sel = alu_out;
  end

  // Branch condition on forwarded registers and redirect target (JALR clears bit 0)
  always_comb begin
    case (idu_branch_opcode)
      3'b000:  br_taken = (fwd_rs1 == fwd_rs2);
      3'b001:  br_taken = (fwd_rs1 != fwd_rs2);
      3'b100:  br_taken = ($signed(fwd_rs1) <  $signed(fwd_rs2));
      3'b101:  br_taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      3'b110:  br_taken = (fwd_rs1 <  fwd_rs2);
      3'b111:  br_taken = (fwd_rs1 >= fwd_rs2);
      default: br_taken = 1'b0;
    endcase
    if (idu_jump_en && !idu_alu_pc_en) br_target = (fwd_rs1 + idu_imm) & ~XLEN'(1);
    else                               br_target = idu_pc + idu_imm;
  end

  // Next register image: a bubble while flushing, otherwise the current instruction
  always_comb begin
    ex_d = '0;
    if (!flush_nop) begin
      ex_d.index_rd      = idu_index_rd;
      ex_d.index_rs1     = idu_index_rs1;
      ex_d.index_rs2     = idu_index_rs2;
      ex_d.jump_en       = idu_jump_en;
      ex_d.branch_en     = idu_branch_en;
      ex_d.branch_pc     = br_target;
      ex_d.branch_result = br_taken;
      ex_d.alu_result    = alu_sel;
      ex_d.gpr_data2     = fwd_rs2;
      ex_d.imm           = idu_imm;
      ex_d.load_en       = idu_load_en;
      ex_d.load_opcode   = idu_load_opcode;
      ex_d.store_en      = idu_store_en;
      ex_d.store_len     = idu_store_len;
      ex_d.wb_en         = idu_wb_en;
      ex_d.wb_choose     = idu_wb_choose;
    end
  end

  // EX/MEM pipeline register, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign exu_index_rd      = ex_q.index_rd;
  assign exu_index_rs1     = ex_q.index_rs1;
  assign exu_index_rs2     = ex_q.index_rs2;
  assign exu_jump_en       = ex_q.jump_en;
  assign exu_branch_en     = ex_q.branch_en;
  assign exu_branch_pc     = ex_q.branch_pc;
  assign exu_branch_result = ex_q.branch_result;
  assign exu_alu_result    = ex_q.alu_result;
  assign exu_gpr_data2     = ex_q.gpr_data2;
  assign exu_imm           = ex_q.imm;
  assign exu_load_en       = ex_q.load_en;
  assign exu_load_opcode   = ex_q.load_opcode;
  assign exu_store_en      = ex_q.store_en;
  assign exu_store_len     = ex_q.store_len;
  assign exu_wb_en         = ex_q.wb_en;
  assign exu_wb_choose     = ex_q.wb_choose;

endmodule

// File: tb/tb_exu_stage.sv
// tb_exu_stage: directed and random stimulus for exu_stage against a behavioural model.
// The model tracks the expected EX/MEM register contents and derives forwarding from them.
// Inputs change 1 ns after a rising edge; combinational outputs sampled at the falling edge.
module tb_exu_stage;

  logic        clk, rstn;
  logic [4:0]  idu_index_rd, idu_index_rs1, idu_index_rs2;
  logic [63:0] idu_pc, idu_gpr_data1, idu_gpr_data2, idu_imm;
  logic [4:0]  idu_alu_opcode;
  logic        idu_alu_en, idu_alu_imm_en, idu_alu_pc_en, idu_alu_halfop;
  logic [2:0]  idu_branch_opcode;
  logic        idu_jump_en, idu_branch_en, idu_load_en;
  logic [2:0]  idu_load_opcode;
  logic        idu_store_en;
  logic [3:0]  idu_store_len;
  logic        idu_wb_en;
  logic [2:0]  idu_wb_choose;
  logic [4:0]  mmu_index_rd;
  logic [63:0] mmu_wb_data;
  logic        mmu_wb_en, mmu_jump_en, mmu_branch_en;
  logic [4:0]  exu_index_rd, exu_index_rs1, exu_index_rs2;
  logic        exu_jump_en, exu_branch_en;
  logic [63:0] exu_branch_pc;
  logic        exu_branch_result;
  logic [63:0] exu_alu_result, exu_gpr_data2, exu_imm;
  logic        exu_load_en;
  logic [2:0]  exu_load_opcode;
  logic        exu_store_en;
  logic [3:0]  exu_store_len;
  logic        exu_wb_en;
  logic [2:0]  exu_wb_choose;
  logic        flush_nop, fw_en1, fw_en2;

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2;
    logic        jump, br;
    logic [63:0] bpc;
    logic        bres;
    logic [63:0] alu, d2, imm;
    logic        ld;
    logic [2:0]  ldop;
    logic        st;
    logic [3:0]  stlen;
    logic        wb;
    logic [2:0]  wbc;
  } ex_t;

  ex_t  mdl;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic last_fw1;

  exu_stage #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn),
    .idu_index_rd(idu_index_rd), .idu_index_rs1(idu_index_rs1), .idu_index_rs2(idu_index_rs2),
    .idu_pc(idu_pc), .idu_gpr_data1(idu_gpr_data1), .idu_gpr_data2(idu_gpr_data2), .idu_imm(idu_imm),
    .idu_alu_opcode(idu_alu_opcode), .idu_alu_en(idu_alu_en), .idu_alu_imm_en(idu_alu_imm_en),
    .idu_alu_pc_en(idu_alu_pc_en), .idu_alu_halfop(idu_alu_halfop),
    .idu_branch_opcode(idu_branch_opcode), .idu_jump_en(idu_jump_en), .idu_branch_en(idu_branch_en),
    .idu_load_en(idu_load_en), .idu_load_opcode(idu_load_opcode), .idu_store_en(idu_store_en),
    .idu_store_len(idu_store_len), .idu_wb_en(idu_wb_en), .idu_wb_choose(idu_wb_choose),
    .mmu_index_rd(mmu_index_rd), .mmu_wb_data(mmu_wb_data), .mmu_wb_en(mmu_wb_en),
    .mmu_jump_en(mmu_jump_en), .mmu_branch_en(mmu_branch_en),
    .exu_index_rd(exu_index_rd), .exu_index_rs1(exu_index_rs1), .exu_index_rs2(exu_index_rs2),
    .exu_jump_en(exu_jump_en), .exu_branch_en(exu_branch_en), .exu_branch_pc(exu_branch_pc),
    .exu_branch_result(exu_branch_result), .exu_alu_result(exu_alu_result),
    .exu_gpr_data2(exu_gpr_data2), .exu_imm(exu_imm), .exu_load_en(exu_load_en),
    .exu_load_opcode(exu_load_opcode), .exu_store_en(exu_store_en), .exu_store_len(exu_store_len),
    .exu_wb_en(exu_wb_en), .exu_wb_choose(exu_wb_choose),
    .flush_nop(flush_nop), .fw_en1(fw_en1), .fw_en2(fw_en2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t dut_state();
    ex_t s;
    s.rd = exu_index_rd;   s.rs1 = exu_index_rs1; s.rs2 = exu_index_rs2;
    s.jump = exu_jump_en;  s.br = exu_branch_en;  s.bpc = exu_branch_pc;
    s.bres = exu_branch_result; s.alu = exu_alu_result; s.d2 = exu_gpr_data2;
    s.imm = exu_imm;       s.ld = exu_load_en;    s.ldop = exu_load_opcode;
    s.st = exu_store_en;   s.stlen = exu_store_len;
    s.wb = exu_wb_en;      s.wbc = exu_wb_choose;
    return s;
  endfunction

  // Reference ALU: W forms extend the low words to 64 bits, compute at full width, keep the low word
  function automatic logic [63:0] alu_ref(input int op, input logic [63:0] a, input logic [63:0] b, input logic w);
    logic [63:0]  x, y, r;
    logic [127:0] p;
    bit           sa, sb;
    int           sh;
    longint       sx, sy;
    sa = (op == 3) || (op == 7) || (op == 12) || (op == 13) || (op == 15) || (op == 17);
    sb = (op == 3) || (op == 12) || (op == 15) || (op == 17);
    x  = w ? (sa ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    y  = w ? (sb ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    sh = w ? int'(b[4:0]) : int'(b[5:0]);
    p  = (sa ? {{64{x[63]}}, x} : {64'd0, x}) * (sb ? {{64{y[63]}}, y} : {64'd0, y});
    sx = x; sy = y;
    case (op)
      0:  r = x + y;
      1:  r = x - y;
      2:  r = x << sh;
      3:  r = (sx < sy) ? 64'd1 : 64'd0;
      4:  r = (x < y) ? 64'd1 : 64'd0;
      5:  r = x ^ y;
      6:  r = x >> sh;
      7:  r = sx >>> sh;
      8:  r = x | y;
      9:  r = x & y;
      10: r = y;
      11: r = p[63:0];
      12, 13, 14: r = w ? {32'd0, p[63:32]} : p[127:64];
      15, 17: begin
        if (y == 0) r = (op == 15) ? '1 : x;
        else if (x == 64'h8000_0000_0000_0000 && y == '1) r = (op == 15) ? x : 64'd0;
        else r = (op == 15) ? sx / sy : sx % sy;
      end
      16, 18: begin
        if (y == 0) r = (op == 16) ? '1 : x;
        else r = (op == 16) ? x / y : x % y;
      end
      default: r = 64'd0;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Expected forwarding flags and next register image from current inputs and modelled state
  task automatic model(output ex_t n, output logic f1, output logic f2, output logic fl);
    logic        e1, e2, m1, m2, take;
    logic [63:0] r1, r2, a, b;
    e1 = mdl.wb && !mdl.ld && mdl.rd != 0 && mdl.rd == idu_index_rs1;
    e2 = mdl.wb && !mdl.ld && mdl.rd != 0 && mdl.rd == idu_index_rs2;
    m1 = mmu_wb_en && mmu_index_rd != 0 && mmu_index_rd == idu_index_rs1;
    m2 = mmu_wb_en && mmu_index_rd != 0 && mmu_index_rd == idu_index_rs2;
    r1 = e1 ? mdl.alu : (m1 ? mmu_wb_data : idu_gpr_data1);
    r2 = e2 ? mdl.alu : (m2 ? mmu_wb_data : idu_gpr_data2);
    f1 = e1 || m1;
    f2 = e2 || m2;
    fl = mmu_jump_en || mmu_branch_en;
    a  = idu_alu_pc_en ? idu_pc : r1;
    b  = idu_alu_imm_en ? idu_imm : r2;
    case (idu_branch_opcode)
      0: take = r1 == r2;
      1: take = r1 != r2;
      4: take = longint'(r1) < longint'(r2);
      5: take = longint'(r1) >= longint'(r2);
      6: take = r1 < r2;
      7: take = r1 >= r2;
      default: take = 1'b0;
    endcase
    n = '0;
    if (!fl) begin
      n.rd = idu_index_rd; n.rs1 = idu_index_rs1; n.rs2 = idu_index_rs2;
      n.jump = idu_jump_en; n.br = idu_branch_en; n.bres = take;
      n.bpc = (idu_jump_en && !idu_alu_pc_en) ? ((r1 + idu_imm) & ~64'd1) : idu_pc + idu_imm;
      n.alu = idu_jump_en ? idu_pc + 64'd4 :
              (idu_alu_en ? alu_ref(int'(idu_alu_opcode), a, b, idu_alu_halfop) : 64'd0);
      n.d2 = r2; n.imm = idu_imm; n.ld = idu_load_en; n.ldop = idu_load_opcode;
      n.st = idu_store_en; n.stlen = idu_store_len; n.wb = idu_wb_en; n.wbc = idu_wb_choose;
    end
  endtask

  task automatic step(input string tag);
    ex_t  n;
    logic f1, f2, fl;
    model(n, f1, f2, fl);
    @(negedge clk);
    last_fw1 = fw_en1;
    check({tag, ".fw_en1"}, 320'(fw_en1), 320'(f1));
    check({tag, ".fw_en2"}, 320'(fw_en2), 320'(f2));
    check({tag, ".flush_nop"}, 320'(flush_nop), 320'(fl));
    @(posedge clk);
    #1;
    check({tag, ".alu_result"}, 320'(exu_alu_result), 320'(n.alu));
    check({tag, ".exu_regs"}, 320'(dut_state()), 320'(n));
    mdl = n;
  endtask

  task automatic clear_inputs();
    idu_index_rd = 0; idu_index_rs1 = 0; idu_index_rs2 = 0;
    idu_pc = 0; idu_gpr_data1 = 0; idu_gpr_data2 = 0; idu_imm = 0;
    idu_alu_opcode = 0; idu_alu_en = 0; idu_alu_imm_en = 0; idu_alu_pc_en = 0; idu_alu_halfop = 0;
    idu_branch_opcode = 0; idu_jump_en = 0; idu_branch_en = 0;
    idu_load_en = 0; idu_load_opcode = 0; idu_store_en = 0; idu_store_len = 0;
    idu_wb_en = 0; idu_wb_choose = 0;
    mmu_index_rd = 0; mmu_wb_data = 0; mmu_wb_en = 0; mmu_jump_en = 0; mmu_branch_en = 0;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [63:0] d1, input logic [63:0] d2);
    clear_inputs();
    idu_alu_en = 1; idu_wb_en = 1; idu_alu_opcode = op;
    idu_index_rd = rd; idu_index_rs1 = rs1; idu_index_rs2 = rs2;
    idu_gpr_data1 = d1; idu_gpr_data2 = d2;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'h0000_0000_8000_0000;
      6: return {32'd0, 32'($urandom())};
      default: return {32'($urandom()), 32'($urandom())};
    endcase
  endfunction

  initial begin
    mdl = '0;
    rstn = 1'b1;
    clear_inputs();
    #12;
    check("reset.exu_regs", 320'(dut_state()), 320'd0);
    check("reset.flush_nop", 320'(flush_nop), 320'd0);
    rstn = 1'b0;

    // ADD x1 = 3 + 4, then consume x1 with a conflicting MEM writeback to x1
    set_op(0, 1, 2, 3, 64'd3, 64'd4);
    step("add_x1");
    check("add_x1.value", 320'(exu_alu_result), 320'd7);
    set_op(0, 4, 1, 5, 64'd999, 64'd10);
    mmu_wb_en = 1; mmu_index_rd = 1; mmu_wb_data = 64'd100;
    step("fwd_ex_wins");
    check("fwd_ex_wins.fw1", 320'(last_fw1), 320'd1);
    check("fwd_ex_wins.value", 320'(exu_alu_result), 320'd17);

    // rd = x0 never forwards, from EX or MEM
    set_op(0, 0, 6, 7, 64'd1, 64'd1);
    step("write_x0");
    set_op(0, 10, 0, 8, 64'd0, 64'd5);
    mmu_wb_en = 1; mmu_index_rd = 0; mmu_wb_data = 64'd55;
    step("no_fwd_x0");
    check("no_fwd_x0.fw1", 320'(last_fw1), 320'd0);
    check("no_fwd_x0.value", 320'(exu_alu_result), 320'd5);

    // MEM-only forwarding
    set_op(0, 30, 9, 11, 64'd1, 64'd2);
    mmu_wb_en = 1; mmu_index_rd = 9; mmu_wb_data = 64'd20;
    step("fwd_mem");
    check("fwd_mem.value", 320'(exu_alu_result), 320'd22);

    // Word operations
    set_op(0, 30, 2, 3, 64'h7FFF_FFFF, 64'd0);
    idu_alu_imm_en = 1; idu_imm = 64'd1; idu_alu_halfop = 1;
    step("addw");
    check("addw.value", 320'(exu_alu_result), 320'(64'hFFFF_FFFF_8000_0000));
    set_op(7, 30, 2, 3, 64'h8000_0000, 64'd0);
    idu_alu_imm_en = 1; idu_imm = 64'd4; idu_alu_halfop = 1;
    step("sraw");
    check("sraw.value", 320'(exu_alu_result), 320'(64'hFFFF_FFFF_F800_0000));

    // Division corner cases
    set_op(15, 30, 2, 3, 64'd7, 64'd0);
    step("div_by0");
    check("div_by0.value", 320'(exu_alu_result), 320'(64'hFFFF_FFFF_FFFF_FFFF));
    set_op(17, 30, 2, 3, 64'd7, 64'd0);
    step("rem_by0");
    check("rem_by0.value", 320'(exu_alu_result), 320'd7);
    set_op(15, 30, 2, 3, 64'h8000_0000_0000_0000, '1);
    step("div_ovf");
    check("div_ovf.value", 320'(exu_alu_result), 320'(64'h8000_0000_0000_0000));

    // Branch compare and JALR target
    set_op(0, 0, 2, 3, '1, 64'd1);
    idu_alu_en = 0; idu_wb_en = 0; idu_branch_en = 1; idu_branch_opcode = 3'b100;
    step("blt");
    check("blt.result", 320'(exu_branch_result), 320'd1);
    idu_branch_opcode = 3'b110;
    step("bltu");
    check("bltu.result", 320'(exu_branch_result), 320'd0);
    set_op(0, 30, 2, 3, 64'h1001, 64'd0);
    idu_alu_en = 0; idu_jump_en = 1; idu_imm = 64'd2; idu_pc = 64'h400;
    step("jalr");
    check("jalr.target", 320'(exu_branch_pc), 320'(64'h1002));
    check("jalr.link", 320'(exu_alu_result), 320'(64'h404));

    // Asynchronous reset mid-run
    set_op(0, 30, 2, 3, 64'd2, 64'd3);
    step("pre_reset");
    check("pre_reset.value", 320'(exu_alu_result), 320'd5);
    #2 rstn = 1'b1;
    #1 check("async_reset.exu_regs", 320'(dut_state()), 320'd0);
    rstn = 1'b0;
    mdl = '0;

    // MEM redirect squashes a valid instruction
    set_op(0, 5, 2, 3, 64'd9, 64'd9);
    idu_store_en = 1; idu_store_len = 4'hF; idu_imm = 64'h40;
    mmu_branch_en = 1;
    step("flush");
    check("flush.bubble", 320'(dut_state()), 320'd0);

    // Random traffic over a small register window so forwarding triggers often
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      idu_alu_opcode    = 5'($urandom_range(0, 20));
      idu_alu_en        = ($urandom_range(0, 7) != 0);
      idu_alu_imm_en    = 1'($urandom());
      idu_alu_pc_en     = ($urandom_range(0, 5) == 0);
      idu_alu_halfop    = ($urandom_range(0, 3) == 0);
      idu_index_rd      = 5'($urandom_range(0, 3));
      idu_index_rs1     = 5'($urandom_range(0, 3));
      idu_index_rs2     = 5'($urandom_range(0, 3));
      idu_gpr_data1     = pick();
      idu_gpr_data2     = pick();
      idu_imm           = pick();
      idu_pc            = {32'($urandom()), 30'($urandom()), 2'b00};
      idu_branch_opcode = 3'($urandom());
      idu_branch_en     = 1'($urandom());
      idu_jump_en       = ($urandom_range(0, 7) == 0);
      idu_load_en       = ($urandom_range(0, 3) == 0);
      idu_load_opcode   = 3'($urandom());
      idu_store_en      = ($urandom_range(0, 3) == 0);
      idu_store_len     = 4'($urandom());
      idu_wb_en         = ($urandom_range(0, 3) != 0);
      idu_wb_choose     = 3'($urandom());
      mmu_wb_en         = 1'($urandom());
      mmu_index_rd      = 5'($urandom_range(0, 3));
      mmu_wb_data       = pick();
      mmu_jump_en       = ($urandom_range(0, 19) == 0);
      mmu_branch_en     = ($urandom_range(0, 19) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_stage.md
Name: exu_stage

Overview:
- Execute stage of the 5-stage RV64 pipeline (IFU, IDU, EXU, MMU, WB). Sits between IDU and MMU.
- Combines operand forwarding, the ALU with the branch comparator and target adder, the EX/MEM pipeline register, and flush generation.
- All ALU, forwarding and branch logic is combinational from the idu_* inputs. Results are captured into the exu_* registers on the rising edge of clk.

Parameters:
- XLEN, 64, datapath width (only 64 supported).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-high (asserted = 1).
- idu_index_rd / idu_index_rs1 / idu_index_rs2  in  5 each  register indices of the instruction in EX.
- idu_pc  in  64  instruction PC.
- idu_gpr_data1 / idu_gpr_data2  in  64 each  register-file read data.
- idu_imm  in  64  sign-extended immediate.
- idu_alu_opcode  in  5  ALU operation.
- idu_alu_en / idu_alu_imm_en / idu_alu_pc_en / idu_alu_halfop  in  1 each  ALU enable; B=imm; A=pc; 32-bit (W) op.
- idu_branch_opcode  in  3  branch funct3.
- idu_jump_en / idu_branch_en  in  1 each  jump (JAL/JALR) / conditional branch.
- idu_load_en, idu_load_opcode[3], idu_store_en, idu_store_len[4], idu_wb_en, idu_wb_choose[3]  in  memory and writeback controls, passed through.
- mmu_index_rd  in  5, mmu_wb_data  in  64, mmu_wb_en  in  1  MEM-stage writeback, used for forwarding.
- mmu_jump_en / mmu_branch_en  in  1 each  taken-redirect indication from MEM.
- exu_* outputs (registered): index_rd/rs1/rs2[5], jump_en, branch_en, branch_pc[64], branch_result, alu_result[64], gpr_data2[64], imm[64], load_en, load_opcode[3], store_en, store_len[4], wb_en, wb_choose[3].
- flush_nop  out  1  flush request to IFU, IDU and this stage.
- fw_en1 / fw_en2  out  1 each  forwarding active for rs1 / rs2 (combinational).

Behaviour:
- Reset: every exu_* register is cleared to 0 immediately while rstn=1, independent of clk.
- Flush: flush_nop = mmu_jump_en | mmu_branch_en (combinational). When flush_nop=1 at a clock edge, the exu_* registers load the all-zero bubble instead of the idu_* values.
- Forwarding for rs1 (rs2 identical):
  - Priority 1, EX stage: exu_wb_en && !exu_load_en && exu_index_rd!=0 && exu_index_rd==idu_index_rs1. Source is exu_alu_result.
  - Priority 2, MEM stage: mmu_wb_en && mmu_index_rd!=0 && mmu_index_rd==idu_index_rs1. Source is mmu_wb_data.
  - Otherwise: idu_gpr_data1.
  - fw_en1 is high when either priority hits.
  - Load-use hazards are stalled by the hazard unit elsewhere, so no load data is forwarded from EX.
- Operands: A = idu_alu_pc_en ? idu_pc : fwd_rs1. B = idu_alu_imm_en ? idu_imm : fwd_rs2.
- ALU opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI).
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
  - Any other opcode gives 0.
- Shift amount: B[5:0] for 64-bit operations, B[4:0] for W operations.
- halfop (W operations):
  - Operate on the low 32 bits of the operands.
  - SRL zero-extends the low word before shifting; SRA sign-extends it.
  - The 32-bit result is sign-extended to 64 bits.
- Division follows RISC-V:
  - Divide by zero: quotient is all-ones, remainder is the dividend.
  - Signed overflow (most-negative / -1): quotient is the dividend, remainder is 0.
- alu_result selection:
  - idu_jump_en=1: alu_result = idu_pc+4 (link value).
  - Otherwise, idu_alu_en=0: alu_result = 0.
  - Otherwise: the ALU output.
- Branch comparison: funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU, on fwd_rs1 vs fwd_rs2. Other codes give 0. branch_result is registered as computed; MEM qualifies it with branch_en.
- Target, exu_branch_pc:
  - JALR (jump_en && !alu_pc_en): (fwd_rs1 + imm) & ~1.
  - Otherwise: idu_pc + imm.
- exu_gpr_data2 = fwd_rs2 (store data). All other controls pass through with 1-cycle latency.
- Back-to-back dependent ALU ops run without stalls.

Test Plan:
- Reset: assert rstn mid-run with exu_alu_result=5 -> all exu_* read 0 before the next clk edge.
- Forwarding priority:
  - ADD x1 = 3+4; next instruction rs1=x1 -> fw_en1=1 and the next exu_alu_result uses 7.
  - With exu_index_rd=mmu_index_rd=1 and different data -> the EX value wins.
  - rd=x0 -> no forwarding.
- W ops: ADDW 0x7FFFFFFF+1 -> 0xFFFFFFFF80000000. SRAW of 0x80000000 by 4 -> 0xFFFFFFFFF8000000.
- Division: DIV 7/0 -> 0xFFFF_FFFF_FFFF_FFFF. REM 7%0 -> 7. DIV 0x8000000000000000 / -1 -> 0x8000000000000000.
- Branches and jumps:
  - BLT -1 vs 1 -> branch_result=1; BLTU -1 vs 1 -> 0.
  - JALR with rs1=0x1001, imm=2 -> branch_pc=0x1002 and alu_result=pc+4.
- Flush: mmu_branch_en=1 -> flush_nop=1 and the next exu_* registers are all 0, even with valid idu_* inputs.
